// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus initiator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_bus_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 32;
  localparam int WORDS_PER_BLOCK = 8;
  // One extra bit so the beat counter can reach WORDS_PER_BLOCK without wrapping.
  localparam int BEAT_W          = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SEND_ADDR,
    ST_RX_BEATS,
    ST_SEND_DATA,
    ST_WAIT_DROP,
    ST_DONE
  } state_e;

  // Clear the in-block word offset so a refill always starts at word 0 of the line.
  function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'(WORDS_PER_BLOCK - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/mem_line_buf.sv
// Line capture buffer: assembles refill beats and holds the last completed line.
// Latency: a captured word lands 1 cycle after cap_en_i; commit publishes on the same edge.
// Backpressure: none, writes are accepted every cycle they are enabled.
//
// Ports: clk_i/rst_i (async active-high), cap_en_i/cap_idx_i/cap_dat_i write one word
// of the working line, commit_i copies the working line (including the word written this
// cycle) to line_o, which holds until the next commit.
module mem_line_buf #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 8,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cap_en_i,
  input  logic [IDX_W-1:0]        cap_idx_i,
  input  logic [DATA_W-1:0]       cap_dat_i,
  input  logic                    commit_i,
  output logic [DATA_W*WORDS-1:0] line_o
);

  logic [WORDS-1:0][DATA_W-1:0] work_q, work_d;
  logic [WORDS-1:0][DATA_W-1:0] line_q;

  always_comb begin
    work_d = work_q;
    if (cap_en_i) work_d[cap_idx_i] = cap_dat_i;
  end

  // The published line only changes on commit, so a partial or abandoned refill never shows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q <= '0;
      line_q <= '0;
    end else begin
      work_q <= work_d;
      if (commit_i) line_q <= work_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/mem_bus_master.sv
// Memory-bus initiator: turns one cache request into a LOAD burst or a STORE handshake.
// Latency: accept to RESP_VALID is 11 cycles (LOAD) / 5 cycles (STORE) with READY high.
// Backpressure: REQ_READY low outside IDLE; READY low stalls each bus phase indefinitely.
//
// Ports: CLK/RST (async active-high); REQ_* cache request, RESP_* one-cycle completion
// with the refilled line (word 0 in LSBs); VALID/LOAD/STORE/ACK/READY bus handshake;
// BUS_DOUT/BUS_OE/BUS_DIN split view of the shared DATA lines.
// Build option: define MEM_TIMEOUT_EN to add a watchdog that ends a stuck transaction
// after TIMEOUT_CYCLES with RESP_ERR=1; otherwise RESP_ERR is tied low.
module mem_bus_master #(
  parameter int DATA_W          = mem_bus_pkg::DATA_W,
  parameter int ADDR_W          = mem_bus_pkg::ADDR_W,
  parameter int WORDS_PER_BLOCK = mem_bus_pkg::WORDS_PER_BLOCK,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic                              REQ_WRITE,
  input  logic [ADDR_W-1:0]                 REQ_ADDR,
  input  logic [DATA_W-1:0]                 REQ_WDATA,
  output logic                              RESP_VALID,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] RESP_LINE,
  output logic                              RESP_ERR,
  output logic                              VALID,
  output logic                              LOAD,
  output logic                              STORE,
  input  logic                              READY,
  output logic                              ACK,
  output logic [DATA_W-1:0]                 BUS_DOUT,
  output logic                              BUS_OE,
  input  logic [DATA_W-1:0]                 BUS_DIN
);
  import mem_bus_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                beat_acc;
  logic                commit;

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    beat_d     = beat_q;
    beat_acc   = 1'b0;
    commit     = 1'b0;
    REQ_READY  = 1'b0;
    VALID      = 1'b0;
    LOAD       = 1'b0;
    STORE      = 1'b0;
    ACK        = 1'b0;
    RESP_VALID = 1'b0;
    BUS_OE     = 1'b0;
    BUS_DOUT   = '0;

    unique case (state_q)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          wr_d    = REQ_WRITE;
          addr_d  = REQ_WRITE ? REQ_ADDR : block_align(REQ_ADDR);
          wdata_d = REQ_WDATA;
          beat_d  = '0;
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        VALID = 1'b1;
        LOAD  = !wr_q;
        STORE = wr_q;
        if (READY) state_d = ST_SEND_ADDR;
      end
      ST_SEND_ADDR: begin
        VALID    = 1'b1;
        LOAD     = !wr_q;
        STORE    = wr_q;
        BUS_OE   = 1'b1;
        BUS_DOUT = DATA_W'(addr_q);
        state_d  = wr_q ? ST_SEND_DATA : ST_RX_BEATS;
      end
      ST_RX_BEATS: begin
        VALID = 1'b1;
        LOAD  = 1'b1;
        if (READY) begin
          beat_acc = 1'b1;
          beat_d   = beat_q + 1'b1;
          // Last beat publishes the line on the same edge it is captured.
          if (beat_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            commit  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND_DATA: begin
        VALID    = 1'b1;
        STORE    = 1'b1;
        BUS_OE   = 1'b1;
        BUS_DOUT = wdata_q;
        state_d  = ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        VALID = 1'b1;
        STORE = 1'b1;
        if (!READY) state_d = ST_DONE;
      end
      ST_DONE: begin
        ACK        = 1'b1;
        RESP_VALID = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MEM_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == ST_IDLE && REQ_VALID) err_d = 1'b0;
    // Only fires when the normal transition did not happen this cycle.
    if ((state_q == ST_WAIT_RDY || state_q == ST_RX_BEATS || state_q == ST_WAIT_DROP) &&
        state_d == state_q && !beat_acc && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_DONE;
      err_d   = 1'b1;
    end
    if (state_d != state_q || beat_acc) wd_d = '0;
    else if (state_q == ST_WAIT_RDY || state_q == ST_RX_BEATS || state_q == ST_WAIT_DROP)
      wd_d = wd_q + 1'b1;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign RESP_ERR = (state_q == ST_DONE) && err_q;
`else
  assign RESP_ERR = 1'b0;
`endif

  mem_line_buf #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS_PER_BLOCK),
    .IDX_W  (IDX_W)
  ) u_line_buf (
    .clk_i     (CLK),
    .rst_i     (RST),
    .cap_en_i  (beat_acc),
    .cap_idx_i (beat_q[IDX_W-1:0]),
    .cap_dat_i (BUS_DIN),
    .commit_i  (commit),
    .line_o    (RESP_LINE)
  );

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural memory slave plus request-level reference model.
// Latency: n/a.
// Backpressure: slave inserts READY delays, beat stalls and slow READY drop per request.
module tb_mem_bus_master;
  localparam int DW = 32, AW = 32, WPB = 8, TO = 16;

  logic CLK, RST, REQ_VALID, REQ_READY, REQ_WRITE, RESP_VALID, RESP_ERR;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA, BUS_DOUT, BUS_DIN;
  logic [DW*WPB-1:0] RESP_LINE;
  logic VALID, LOAD, STORE, READY, ACK, BUS_OE;

  mem_bus_master #(.DATA_W(DW), .ADDR_W(AW), .WORDS_PER_BLOCK(WPB), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .RESP_VALID(RESP_VALID), .RESP_LINE(RESP_LINE),
    .RESP_ERR(RESP_ERR), .VALID(VALID), .LOAD(LOAD), .STORE(STORE), .READY(READY), .ACK(ACK),
    .BUS_DOUT(BUS_DOUT), .BUS_OE(BUS_OE), .BUS_DIN(BUS_DIN));

  int checks = 0, failures = 0;
  int cyc = 0, oe_cnt = 0, resp_cnt = 0, ack_cnt = 0, both_hi = 0;

  logic [31:0] smem [0:255];   // memory seen by the bus slave
  logic [31:0] rmem [0:255];   // reference model memory, updated from requests
  int rdy_delay = 0, drop_delay = 0;
  int stall_before [WPB];
  bit never_ready = 0;
  int s_phase = 0, s_cnt = 0, s_k = 0, s_left = 0;
  logic [31:0] s_addr, bus_addr_seen;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (BUS_OE) oe_cnt++;
    if (RESP_VALID) resp_cnt++;
    if (ACK) ack_cnt++;
    if (LOAD && STORE) both_hi++;
  end

  // Bus slave: decides READY / data for the coming edge at every falling edge.
  initial begin
    READY = 0; BUS_DIN = '0; s_addr = '0; bus_addr_seen = '0;
    forever begin
      @(negedge CLK);
      if (!VALID) begin
        READY = 0; s_phase = 0; s_cnt = 0;
      end else begin
        case (s_phase)
          0: if (!never_ready && s_cnt >= rdy_delay) begin READY = 1; s_phase = 1; end
             else begin READY = 0; s_cnt++; end
          1: if (BUS_OE) begin
               s_addr = BUS_DOUT; bus_addr_seen = BUS_DOUT; READY = 0; s_k = 0;
               if (LOAD) begin s_left = stall_before[0]; s_phase = 2; end
               else s_phase = 3;
             end
          2: if (s_k >= WPB) READY = 0;
             else if (s_left > 0) begin READY = 0; s_left--; end
             else begin
               READY = 1;
               BUS_DIN = smem[8'(s_addr + 32'(s_k))];
               s_k++;
               s_left = (s_k < WPB) ? stall_before[s_k] : 0;
             end
          3: begin
               READY = 0;
               if (BUS_OE) begin smem[8'(s_addr)] = BUS_DOUT; s_left = drop_delay; s_phase = 4; end
             end
          default: begin
               READY = (s_left > 0);
               if (s_left > 0) s_left--;
             end
        endcase
      end
    end
  end

  function automatic logic [DW*WPB-1:0] exp_line(input logic [31:0] addr);
    logic [DW*WPB-1:0] r;
    int base;
    base = (int'(addr) / WPB) * WPB;
    for (int k = 0; k < WPB; k++) r[k*DW +: DW] = rmem[(base + k) % 256];
    return r;
  endfunction

  task automatic clear_stalls();
    for (int k = 0; k < WPB; k++) stall_before[k] = 0;
  endtask

  task automatic run_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [DW*WPB-1:0] line, output logic err,
                         output int oe, output int acks, output int resps, output bit ok);
    int a_cyc, r_cyc, oe0, ack0, resp0;
    a_cyc = -1; r_cyc = -1; line = '0; err = 0;
    @(posedge CLK); #1;
    oe0 = oe_cnt; ack0 = ack_cnt; resp0 = resp_cnt;
    REQ_VALID = 1; REQ_WRITE = wr; REQ_ADDR = addr; REQ_WDATA = wdata;
    for (int i = 0; i < 50 && a_cyc < 0; i++) begin
      @(negedge CLK);
      if (REQ_READY) a_cyc = cyc;
    end
    @(posedge CLK); #1 REQ_VALID = 0;
    for (int i = 0; i < 400 && r_cyc < 0 && a_cyc >= 0; i++) begin
      @(negedge CLK);
      if (RESP_VALID) begin r_cyc = cyc; line = RESP_LINE; err = RESP_ERR; end
    end
    @(negedge CLK);
    @(posedge CLK); #1;
    oe = oe_cnt - oe0; acks = ack_cnt - ack0; resps = resp_cnt - resp0;
    lat = r_cyc - a_cyc;
    ok = (a_cyc >= 0) && (r_cyc >= 0);
  endtask

  task automatic test_reset();
    RST = 1; REQ_VALID = 0; REQ_WRITE = 0; REQ_ADDR = '0; REQ_WDATA = '0;
    #3;
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", REQ_READY); end
    checks++; if ({VALID, LOAD, STORE, ACK, RESP_VALID, RESP_ERR, BUS_OE} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got %b want 0000000", {VALID, LOAD, STORE, ACK, RESP_VALID, RESP_ERR, BUS_OE}); end
    checks++; if (BUS_DOUT !== '0) begin failures++; $display("FAIL reset_dout got %h want 0", BUS_DOUT); end
    checks++; if (RESP_LINE !== '0) begin failures++; $display("FAIL reset_line got %h want 0", RESP_LINE); end
    repeat (3) @(posedge CLK);
    #2 RST = 0;
  endtask

  task automatic test_load_basic();
    int lat, oe, acks, resps; logic [DW*WPB-1:0] line; logic err; bit ok;
    for (int i = 0; i < 8; i++) begin smem[16+i] = 32'hA0 + i; rmem[16+i] = 32'hA0 + i; end
    clear_stalls(); rdy_delay = 1;
    run_req(0, 32'h13, 32'h0, lat, line, err, oe, acks, resps, ok);
    checks++; if (!ok) begin failures++; $display("FAIL load_basic_done got timeout want completion"); end
    checks++; if (bus_addr_seen !== 32'h10) begin failures++; $display("FAIL load_basic_addr got %h want 10", bus_addr_seen); end
    checks++; if (line !== exp_line(32'h13)) begin failures++; $display("FAIL load_basic_line got %h want %h", line, exp_line(32'h13)); end
    checks++; if (lat != 12) begin failures++; $display("FAIL load_basic_latency got %0d want 12", lat); end
    checks++; if (oe != 1) begin failures++; $display("FAIL load_basic_oe_cycles got %0d want 1", oe); end
    checks++; if (acks != 1 || resps != 1) begin failures++; $display("FAIL load_basic_pulses got ack=%0d resp=%0d want 1/1", acks, resps); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL load_basic_err got %b want 0", err); end
  endtask

  task automatic test_load_stall();
    int lat, oe, acks, resps; logic [DW*WPB-1:0] line; logic err; bit ok;
    logic [31:0] addr;
    addr = 32'($urandom_range(0, 255));
    clear_stalls(); stall_before[3] = 2; stall_before[6] = 2; rdy_delay = 0;
    run_req(0, addr, 32'h0, lat, line, err, oe, acks, resps, ok);
    clear_stalls();
    checks++; if (!ok || line !== exp_line(addr)) begin failures++; $display("FAIL load_stall_line got %h want %h", line, exp_line(addr)); end
    checks++; if (lat != 15) begin failures++; $display("FAIL load_stall_latency got %0d want 15", lat); end
    checks++; if (oe != 1) begin failures++; $display("FAIL load_stall_oe_cycles got %0d want 1", oe); end
  endtask

  task automatic test_store();
    int lat, oe, acks, resps; logic [DW*WPB-1:0] line, prev; logic err; bit ok;
    prev = RESP_LINE;
    clear_stalls(); rdy_delay = 0; drop_delay = 2;
    run_req(1, 32'h5, 32'hDEADBEEF, lat, line, err, oe, acks, resps, ok);
    rmem[5] = 32'hDEADBEEF;
    drop_delay = 0;
    checks++; if (!ok || smem[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL store_mem got %h want deadbeef", smem[5]); end
    checks++; if (bus_addr_seen !== 32'h5) begin failures++; $display("FAIL store_addr got %h want 5", bus_addr_seen); end
    checks++; if (oe != 2) begin failures++; $display("FAIL store_oe_cycles got %0d want 2", oe); end
    checks++; if (lat != 7) begin failures++; $display("FAIL store_latency got %0d want 7", lat); end
    checks++; if (line !== prev) begin failures++; $display("FAIL store_line_kept got %h want %h", line, prev); end
  endtask

  task automatic test_random();
    int lat, oe, acks, resps, want; logic [DW*WPB-1:0] line, prev; logic err; bit ok, wr;
    logic [31:0] addr, wdata;
    for (int n = 0; n < 16; n++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 255)); wdata = $urandom;
      rdy_delay = $urandom_range(0, 3); drop_delay = $urandom_range(0, 3);
      want = 0;
      for (int k = 0; k < WPB; k++) begin
        stall_before[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        want += stall_before[k];
      end
      prev = RESP_LINE;
      run_req(wr, addr, wdata, lat, line, err, oe, acks, resps, ok);
      if (wr) begin
        rmem[addr[7:0]] = wdata;
        want = 5 + rdy_delay + drop_delay;
        checks++; if (!ok || smem[addr[7:0]] !== wdata || line !== prev) begin
          failures++; $display("FAIL rand_store[%0d] got mem=%h want %h", n, smem[addr[7:0]], wdata); end
      end else begin
        want = 11 + rdy_delay + want;
        checks++; if (!ok || line !== exp_line(addr)) begin
          failures++; $display("FAIL rand_load[%0d] got %h want %h", n, line, exp_line(addr)); end
      end
      checks++; if (lat != want || oe != (wr ? 2 : 1)) begin
        failures++; $display("FAIL rand_timing[%0d] got lat=%0d oe=%0d want lat=%0d oe=%0d", n, lat, oe, want, wr ? 2 : 1); end
    end
    clear_stalls(); rdy_delay = 0; drop_delay = 0;
  endtask

  task automatic test_back_to_back();
    int a1, r1, a2, r2; logic [DW*WPB-1:0] line1;
    logic [31:0] addr1, addr2, wd2;
    addr1 = 32'($urandom_range(0, 255)); addr2 = 32'($urandom_range(0, 255)); wd2 = $urandom;
    a1 = -1; r1 = -1; a2 = -1; r2 = -1; line1 = '0;
    @(posedge CLK); #1;
    REQ_VALID = 1; REQ_WRITE = 0; REQ_ADDR = addr1;
    for (int i = 0; i < 20 && a1 < 0; i++) begin @(negedge CLK); if (REQ_READY) a1 = cyc; end
    @(posedge CLK); #1;
    REQ_WRITE = 1; REQ_ADDR = addr2; REQ_WDATA = wd2;
    for (int i = 0; i < 100 && a2 < 0; i++) begin
      @(negedge CLK);
      if (REQ_READY) a2 = cyc;
      if (RESP_VALID && r1 < 0) begin r1 = cyc; line1 = RESP_LINE; end
    end
    @(posedge CLK); #1 REQ_VALID = 0;
    for (int i = 0; i < 100 && r2 < 0; i++) begin @(negedge CLK); if (RESP_VALID) r2 = cyc; end
    rmem[addr2[7:0]] = wd2;
    checks++; if (r1 < 0 || a2 != r1 + 1) begin failures++; $display("FAIL b2b_second_accept got cycle %0d want %0d", a2, r1 + 1); end
    checks++; if (a2 - a1 != 12) begin failures++; $display("FAIL b2b_busy_window got %0d want 12", a2 - a1); end
    checks++; if (line1 !== exp_line(addr1)) begin failures++; $display("FAIL b2b_line got %h want %h", line1, exp_line(addr1)); end
    checks++; if (r2 < 0 || smem[addr2[7:0]] !== wd2) begin failures++; $display("FAIL b2b_store got %h want %h", smem[addr2[7:0]], wd2); end
  endtask

  task automatic test_reset_mid();
    int lat, oe, acks, resps, resp0, waited; logic [DW*WPB-1:0] line; logic err; bit ok;
    logic [31:0] addr;
    addr = 32'($urandom_range(0, 255));
    clear_stalls(); rdy_delay = 0;
    @(posedge CLK); #1;
    REQ_VALID = 1; REQ_WRITE = 0; REQ_ADDR = addr;
    @(posedge CLK); #1 REQ_VALID = 0;
    waited = 0;
    do begin @(negedge CLK); #1; waited++; end while (s_k != 5 && waited < 40);
    resp0 = resp_cnt;
    RST = 1;
    #1;
    checks++; if (s_k != 5) begin failures++; $display("FAIL rst_mid_reach_beat got %0d want 5", s_k); end
    checks++; if ({VALID, LOAD, STORE, BUS_OE, RESP_VALID} !== 5'b0 || REQ_READY !== 1'b1) begin
      failures++; $display("FAIL rst_mid_outputs got %b rdy=%b want 00000 rdy=1", {VALID, LOAD, STORE, BUS_OE, RESP_VALID}, REQ_READY); end
    checks++; if (RESP_LINE !== '0) begin failures++; $display("FAIL rst_mid_line got %h want 0", RESP_LINE); end
    repeat (2) @(posedge CLK);
    #2 RST = 0;
    repeat (6) @(posedge CLK);
    #1;
    checks++; if (resp_cnt != resp0) begin failures++; $display("FAIL rst_mid_no_resp got %0d want %0d", resp_cnt - resp0, 0); end
    addr = 32'($urandom_range(0, 255));
    run_req(0, addr, 32'h0, lat, line, err, oe, acks, resps, ok);
    checks++; if (!ok || line !== exp_line(addr) || lat != 11) begin
      failures++; $display("FAIL rst_mid_next_load got lat=%0d line=%h want lat=11 line=%h", lat, line, exp_line(addr)); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int lat, oe, acks, resps; logic [DW*WPB-1:0] line, prev; logic err; bit ok;
    prev = RESP_LINE;
    clear_stalls(); never_ready = 1;
    run_req(0, 32'h40, 32'h0, lat, line, err, oe, acks, resps, ok);
    never_ready = 0;
    checks++; if (!ok || lat != TO + 1) begin failures++; $display("FAIL timeout_wait_latency got %0d want %0d", lat, TO + 1); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_wait_err got %b want 1", err); end
    checks++; if (line !== prev) begin failures++; $display("FAIL timeout_wait_line got %h want %h", line, prev); end
    stall_before[2] = TO + 4;
    run_req(0, 32'h80, 32'h0, lat, line, err, oe, acks, resps, ok);
    clear_stalls();
    checks++; if (!ok || lat != 5 + TO || err !== 1'b1 || line !== prev) begin
      failures++; $display("FAIL timeout_beat got lat=%0d err=%b want lat=%0d err=1", lat, err, 5 + TO); end
    run_req(0, 32'h90, 32'h0, lat, line, err, oe, acks, resps, ok);
    checks++; if (!ok || err !== 1'b0 || line !== exp_line(32'h90)) begin
      failures++; $display("FAIL timeout_recover got err=%b line=%h want err=0 line=%h", err, line, exp_line(32'h90)); end
  endtask
`endif

  initial begin
    logic [31:0] v;
    clear_stalls();
    for (int i = 0; i < 256; i++) begin v = $urandom; smem[i] = v; rmem[i] = v; end
    test_reset();
    test_load_basic();
    test_load_stall();
    test_store();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    checks++; if (both_hi != 0) begin failures++; $display("FAIL load_store_exclusive got %0d overlap cycles want 0", both_hi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the word-serial main-memory bus (CLK, VALID, READY, LOAD, STORE, ACK, shared 32-bit DATA).
- Sits between the cache controller and main memory.
- Accepts one cache request at a time:
  - line refill: LOAD, 8-word burst read;
  - write-through: STORE, single word.
- Sequences the bus handshake and returns the assembled line or a store completion to the cache.

Parameters:
- DATA_W, 32, bus/word width in bits
- ADDR_W, 32, word address width
- WORDS_PER_BLOCK, 8, beats per LOAD burst; power of two
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_TIMEOUT_EN

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ_VALID  in  1  cache request present
- REQ_READY  out  1  block can accept request
- REQ_WRITE  in  1  1=STORE, 0=LOAD
- REQ_ADDR  in  ADDR_W  word address
- REQ_WDATA  in  DATA_W  store data
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_LINE  out  DATA_W*WORDS_PER_BLOCK  refilled line, word 0 in LSBs
- RESP_ERR  out  1  completion was a timeout (0 without macro)
- VALID  out  1  bus transaction active
- LOAD  out  1  bus read
- STORE  out  1  bus write
- READY  in  1  memory ready / beat valid
- ACK  out  1  one-cycle end-of-transaction pulse to memory
- BUS_DOUT  out  DATA_W  value driven onto DATA
- BUS_OE  out  1  tristate enable for DATA (top level builds the buffer)
- BUS_DIN  in  DATA_W  value sampled from DATA

Behaviour:
- Reset values (async, immediate):
  - All outputs 0 except REQ_READY=1.
  - State IDLE, beat counter 0, line buffer 0.
- Reset mid-transaction:
  - Abort immediately; partial line is discarded.
  - No RESP_VALID is issued.
  - VALID/LOAD/STORE drop in the same reset window.
- States: IDLE, WAIT_RDY, SEND_ADDR, RX_BEATS, SEND_DATA, WAIT_DROP, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID: latch address and wdata, go to WAIT_RDY.
  - LOAD address is block-aligned: low log2(WORDS_PER_BLOCK) bits cleared.
  - STORE address is used as given.
- WAIT_RDY:
  - VALID=1; LOAD or STORE=1 per REQ_WRITE; BUS_OE=0.
  - Stay until READY=1, then go to SEND_ADDR.
- SEND_ADDR:
  - Exactly one cycle: BUS_OE=1, BUS_DOUT=latched address.
  - Next state: LOAD goes to RX_BEATS, STORE goes to SEND_DATA.
- RX_BEATS:
  - BUS_OE=0.
  - Each cycle with READY=1: capture BUS_DIN into line word[beat], beat++.
  - READY=0 stalls; no capture, counter holds.
  - After beat WORDS_PER_BLOCK-1 is captured, go to DONE.
  - Counter width is log2(WORDS_PER_BLOCK)+1 and never wraps.
- SEND_DATA:
  - One cycle: BUS_OE=1, BUS_DOUT=wdata.
  - Then WAIT_DROP.
- WAIT_DROP:
  - BUS_OE=0; VALID/STORE held.
  - Stay until READY=0, then go to DONE.
- DONE:
  - One cycle: VALID/LOAD/STORE=0, ACK=1, RESP_VALID=1.
  - RESP_LINE valid for LOAD, held until the next LOAD completes; unchanged for STORE.
  - Then IDLE.
- REQ_READY is 0 in every state except IDLE; requests offered while busy wait.
- BUS_OE is never 1 outside SEND_ADDR/SEND_DATA, so the bus is never driven while memory drives it.
- Minimum latencies, accept to RESP_VALID with READY already high:
  - LOAD: 11 cycles (1+1+8+1, plus accept).
  - STORE: 5 cycles.
- LOAD and STORE are never both high.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Watchdog counts cycles spent in WAIT_RDY, RX_BEATS or WAIT_DROP; resets on every state change or accepted beat.
  - On reaching TIMEOUT_CYCLES: go to DONE with RESP_ERR=1 in the RESP_VALID cycle.
  - RESP_LINE is not updated on a timeout.
- Undefined:
  - No counter logic; RESP_ERR tied 0.
  - The block waits on READY indefinitely.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum;
  - WORDS_PER_BLOCK, BEAT_W, DATA_W constants;
  - block_align() function.
- One sub-module, mem_line_buf: WORDS_PER_BLOCK x DATA_W capture register with write-enable and index. It owns RESP_LINE storage.

Test Plan:
- LOAD of REQ_ADDR=0x13, memory words 0x10..0x17 = 0xA0..0xA7, READY high 1 cycle after VALID -> BUS_DOUT=0x10 with BUS_OE for exactly 1 cycle; RESP_LINE = {0xA7..0xA0}; RESP_VALID and ACK each 1 cycle.
- LOAD with READY low on beats 3 and 6 for 2 cycles each -> no duplicate/skipped words; RESP_VALID 4 cycles later than the no-stall case.
- STORE REQ_ADDR=0x5, WDATA=0xDEADBEEF -> address cycle then data cycle, each with BUS_OE=1; mem[5]=0xDEADBEEF; RESP_VALID after READY falls.
- Back-to-back requests held on REQ_VALID -> second accepted only in the cycle after DONE; REQ_READY=0 throughout the first.
- RST asserted at beat 4 of a LOAD -> outputs at reset values immediately; no RESP_VALID; next LOAD completes correctly.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, READY never asserted -> RESP_VALID with RESP_ERR=1 exactly 16 cycles after entering WAIT_RDY; RESP_LINE unchanged.
